// File: rtl/mpu_bus_pkg.sv
// Shared types and constants for the 6502 MPU bus bridge.
package mpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] BUS_ERR_DATA   = 8'hFF;
    localparam int         FAST_BYTES_DEF = 512;
    localparam int         TIMEOUT_DEF    = 255;

endpackage

// File: rtl/mpu_bus_bridge_if.sv
// MPU-side bus cycle and external memory handshake, bundled for the bridge.
interface mpu_bus_bridge_if;

    logic        R_W;
    logic [7:0]  ABL;
    logic [7:0]  ABH;
    logic [7:0]  DB_OUT;
    logic [7:0]  DB_IN;
    logic        RDY;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_ACK;
    logic [7:0]  MEM_RDATA;
    logic        BUS_ERR;

    // master: MPU plus external memory; slave: the bridge
    modport master (
        output R_W, ABL, ABH, DB_OUT, MEM_ACK, MEM_RDATA,
        input  DB_IN, RDY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR
    );

    modport slave (
        input  R_W, ABL, ABH, DB_OUT, MEM_ACK, MEM_RDATA,
        output DB_IN, RDY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, BUS_ERR
    );

endinterface

// File: rtl/mpu_fast_ram.sv
// Zero-wait internal RAM: asynchronous read, synchronous write, contents survive reset.
module mpu_fast_ram #(
    parameter  int FAST_BYTES = 512,
    localparam int AW         = $clog2(FAST_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [FAST_BYTES];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mpu_bus_bridge.sv
// Bridges 6502 bus cycles to internal fast RAM or a REQ/ACK external port,
// stalling the MPU with RDY until slow accesses complete or time out.
module mpu_bus_bridge
    import mpu_bus_pkg::*;
#(
    parameter int FAST_BYTES = FAST_BYTES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input logic             CLK,
    input logic             RES_N,
    mpu_bus_bridge_if.slave bus
);

    localparam int AW = $clog2(FAST_BYTES);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state, state_d;
    logic [15:0]   addr;
    logic          fast;
    logic          rdy;
    logic          timeout_hit;
    logic [CW-1:0] cnt;
    logic          mem_req_q, mem_we_q, bus_err_q;
    logic [15:0]   mem_addr_q;
    logic [7:0]    mem_wdata_q, rdata_q, ram_rdata;

    assign addr        = {bus.ABH, bus.ABL};
    assign fast        = (addr < 16'(FAST_BYTES));
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    mpu_fast_ram #(.FAST_BYTES(FAST_BYTES)) u_ram (
        .clk   (CLK),
        .we    (state == IDLE && fast && !bus.R_W),
        .addr  (addr[AW-1:0]),
        .wdata (bus.DB_OUT),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        rdy     = 1'b0;
        case (state)
            IDLE: begin
                rdy = fast;
                if (!fast) state_d = WAIT;
            end
            WAIT: if (bus.MEM_ACK || timeout_hit) state_d = DONE;
            DONE: begin
                rdy     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ACK is checked before the timeout so a coincident ACK suppresses BUS_ERR
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            cnt         <= '0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                IDLE: if (!fast) begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= !bus.R_W;
                    mem_addr_q  <= addr;
                    mem_wdata_q <= bus.DB_OUT;
                    cnt         <= '0;
                end
                WAIT: begin
                    if (bus.MEM_ACK) begin
                        rdata_q   <= bus.MEM_RDATA;
                        mem_req_q <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q   <= BUS_ERR_DATA;
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.RDY       = rdy;
    assign bus.DB_IN     = (state == IDLE && fast) ? ram_rdata : rdata_q;
    assign bus.MEM_REQ   = mem_req_q;
    assign bus.MEM_WE    = mem_we_q;
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_WDATA = mem_wdata_q;
    assign bus.BUS_ERR   = bus_err_q;

endmodule

// File: tb/tb_mpu_bus_bridge.sv
// Directed bench for mpu_bus_bridge with FAST_BYTES=512, TIMEOUT=4.
module tb_mpu_bus_bridge;

    logic CLK = 1'b0;
    logic RES_N = 1'b1;
    int   checks = 0;
    int   failures = 0;

    int         stalls, reqs, errs;
    logic [7:0] db;
    logic       stable;

    always #5 CLK = ~CLK;

    mpu_bus_bridge_if bus();

    mpu_bus_bridge #(.FAST_BYTES(512), .TIMEOUT(4)) dut (
        .CLK   (CLK),
        .RES_N (RES_N),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [15:0] a, input logic [7:0] d);
        bus.R_W    = rw;
        bus.ABH    = a[15:8];
        bus.ABL    = a[7:0];
        bus.DB_OUT = d;
    endtask

    task automatic fast_cycle(input string tag, input logic rw, input logic [15:0] a,
                              input logic [7:0] d, input logic [7:0] exp_rd);
        drive(rw, a, d);
        @(negedge CLK);
        chk({tag, ".rdy"}, 32'(bus.RDY), 32'd1);
        chk({tag, ".req"}, 32'(bus.MEM_REQ), 32'd0);
        if (rw) chk({tag, ".db"}, 32'(bus.DB_IN), 32'(exp_rd));
        @(posedge CLK); #1;
    endtask

    // ack_lag: REQ cycle index (0 = first) in which ACK is returned; -1 = never
    task automatic slow_cycle(input logic rw, input logic [15:0] a, input logic [7:0] d,
                              input int ack_lag, input logic [7:0] rd,
                              output int n_stall, output int n_req, output int n_err,
                              output logic [7:0] rdb, output logic ok);
        n_stall = 0; n_req = 0; n_err = 0; rdb = 8'h00; ok = 1'b1;
        drive(rw, a, d);
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (bus.BUS_ERR) n_err++;
            if (bus.RDY) begin
                rdb = bus.DB_IN;
                break;
            end
            n_stall++;
            if (bus.MEM_REQ) begin
                if (bus.MEM_ADDR !== a || bus.MEM_WE !== !rw || (!rw && bus.MEM_WDATA !== d))
                    ok = 1'b0;
                bus.MEM_ACK   = (n_req == ack_lag);
                bus.MEM_RDATA = rd;
                n_req++;
            end else begin
                bus.MEM_ACK = 1'b0;
            end
        end
        bus.MEM_ACK = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = 8'h00;
        drive(1'b1, 16'hC000, 8'h00);
        #2 RES_N = 1'b0;
        #10;
        chk("rst.req",   32'(bus.MEM_REQ),   32'd0);
        chk("rst.we",    32'(bus.MEM_WE),    32'd0);
        chk("rst.addr",  32'(bus.MEM_ADDR),  32'd0);
        chk("rst.wdata", 32'(bus.MEM_WDATA), 32'd0);
        chk("rst.err",   32'(bus.BUS_ERR),   32'd0);
        chk("rst.rdy",   32'(bus.RDY),       32'd0);
        chk("rst.db",    32'(bus.DB_IN),     32'd0);
        drive(1'b1, 16'h0000, 8'h00);
        @(negedge CLK) RES_N = 1'b1;
        @(posedge CLK); #1;

        // fast write then read back
        fast_cycle("t1.wr", 1'b0, 16'h0042, 8'h5A, 8'h00);
        fast_cycle("t1.rd", 1'b1, 16'h0042, 8'h00, 8'h5A);

        // slow read, ACK in first REQ cycle
        slow_cycle(1'b1, 16'hC000, 8'h00, 0, 8'hA9, stalls, reqs, errs, db, stable);
        chk("t2.stalls", 32'(stalls), 32'd2);
        chk("t2.reqs",   32'(reqs),   32'd1);
        chk("t2.db",     32'(db),     32'hA9);
        chk("t2.stable", 32'(stable), 32'd1);

        // slow write, ACK in 4th REQ cycle
        slow_cycle(1'b0, 16'h8001, 8'h33, 3, 8'h00, stalls, reqs, errs, db, stable);
        chk("t3.stalls", 32'(stalls), 32'd5);
        chk("t3.reqs",   32'(reqs),   32'd4);
        chk("t3.errs",   32'(errs),   32'd0);
        chk("t3.stable", 32'(stable), 32'd1);

        // timeout, never ACK
        slow_cycle(1'b1, 16'hD000, 8'h00, -1, 8'h77, stalls, reqs, errs, db, stable);
        chk("t4.stalls", 32'(stalls), 32'd5);
        chk("t4.reqs",   32'(reqs),   32'd4);
        chk("t4.errs",   32'(errs),   32'd1);
        chk("t4.db",     32'(db),     32'hFF);
        drive(1'b1, 16'h0042, 8'h00);
        @(negedge CLK);
        chk("t4.err_pulse", 32'(bus.BUS_ERR), 32'd0);
        @(posedge CLK); #1;

        // ACK coincides with the timeout cycle
        slow_cycle(1'b1, 16'hD000, 8'h00, 3, 8'h5C, stalls, reqs, errs, db, stable);
        chk("t4b.stalls", 32'(stalls), 32'd5);
        chk("t4b.errs",   32'(errs),   32'd0);
        chk("t4b.db",     32'(db),     32'h5C);

        // reset in the middle of WAIT
        drive(1'b1, 16'hE000, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        chk("t5.req_wait", 32'(bus.MEM_REQ), 32'd1);
        #1 RES_N = 1'b0;
        #1;
        chk("t5.req_rst", 32'(bus.MEM_REQ), 32'd0);
        drive(1'b1, 16'h0042, 8'h00);
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 8'h11;
        #1;
        chk("t5.rdy_rst", 32'(bus.RDY),   32'd1);
        chk("t5.db_rst",  32'(bus.DB_IN), 32'h5A);
        @(negedge CLK) RES_N = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("t5.late_ack_req", 32'(bus.MEM_REQ), 32'd0);
        chk("t5.late_ack_rdy", 32'(bus.RDY),     32'd1);
        chk("t5.ram_kept",     32'(bus.DB_IN),   32'h5A);
        bus.MEM_ACK = 1'b0;
        @(posedge CLK); #1;

        // address boundaries
        fast_cycle("t6.top_wr", 1'b0, 16'h01FF, 8'hA5, 8'h00);
        fast_cycle("t6.top_rd", 1'b1, 16'h01FF, 8'h00, 8'hA5);
        slow_cycle(1'b1, 16'h0200, 8'h00, 1, 8'h3C, stalls, reqs, errs, db, stable);
        chk("t6.edge_stalls", 32'(stalls), 32'd3);
        chk("t6.edge_db",     32'(db),     32'h3C);
        chk("t6.edge_stable", 32'(stable), 32'd1);
        slow_cycle(1'b1, 16'hFFFF, 8'h00, 0, 8'hC3, stalls, reqs, errs, db, stable);
        chk("t6.ffff_reqs", 32'(reqs), 32'd1);
        chk("t6.ffff_db",   32'(db),   32'hC3);

        // back-to-back slow reads to the same address
        slow_cycle(1'b1, 16'h9000, 8'h00, 0, 8'h12, stalls, reqs, errs, db, stable);
        chk("t6.b2b0_reqs", 32'(reqs), 32'd1);
        chk("t6.b2b0_db",   32'(db),   32'h12);
        slow_cycle(1'b1, 16'h9000, 8'h00, 0, 8'h34, stalls, reqs, errs, db, stable);
        chk("t6.b2b1_stalls", 32'(stalls), 32'd2);
        chk("t6.b2b1_reqs",   32'(reqs),   32'd1);
        chk("t6.b2b1_db",     32'(db),     32'h34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
